johnson_decoder: RTL and testbench
==================================

// Module: johnson_decoder
// PURPOSE
//   Receive end of a Johnson-counter link: samples an N-bit Johnson code and
//   decodes it to a binary index 0..2N-1. Checks code legality and step order.
//   Runs a lock FSM and counts errors. Monitors Johnson counters or
//   Johnson-coded buses crossing between blocks.
// PARAMETERS
//   N        4  Johnson code width; sequence length 2N
//   LOCK_CNT 3  consecutive good steps needed to declare lock (>=1)
//   EW       8  width of saturating error counter
//   IW       derived localparam = $clog2(2N); index width
// PORTS
//   clk         in   1     rising-edge clock
//   rst         in   1     asynchronous reset, active high
//   code_in     in   N     Johnson code sample
//   code_valid  in   1     code_in sampled this cycle when high
//   clr_err     in   1     synchronous clear of err_count
//   idx_out     out  IW    decoded index, registered
//   idx_valid   out  1     1-cycle pulse: idx_out updated
//   code_err    out  1     1-cycle pulse: illegal code sampled
//   seq_err     out  1     1-cycle pulse: legal code, bad step while LOCKED
//   locked      out  1     FSM in LOCKED
//   err_count   out  EW    saturating count of code_err|seq_err events
// BEHAVIOUR
//   Reset: all outputs 0; FSM=UNLOCKED; prev index=0; good count=0.
//   Latency: 1 clk from code_valid edge to idx_valid/code_err/seq_err.
//   Legal code: at most one i in 0..N-2 with code[i]!=code[i+1].
//   Decode: MSB=0 -> idx=popcount(code); MSB=1 -> idx=N+count of zeros.
//     Example N=4: 0000->0, 0111->3, 1111->4, 1000->7.
//   Illegal code: code_err=1, idx_valid=0, idx_out holds, FSM->UNLOCKED.
//   Successor: next = (prev+1) mod 2N; 2N-1 -> 0 wraps legally.
//   Hold: same index as prev = no error, no count change, idx_valid=1.
//   FSM, evaluated only on code_valid with legal code:
//     UNLOCKED: store idx, good=0 -> ACQUIRE.
//     ACQUIRE : successor -> good++; reaching LOCK_CNT -> LOCKED.
//               other non-hold step -> good=0, stay ACQUIRE, no seq_err.
//     LOCKED  : successor/hold -> stay. Other step -> seq_err=1, UNLOCKED.
//   Prev index updates on every legal sample.
//   err_count: +1 per cycle with code_err|seq_err; saturates at 2^EW-1.
//     clr_err with error in same cycle -> err_count=1; clr_err alone -> 0.
//   code_valid=0: no state change; pulses deassert.
//   rst mid-operation: immediate return to reset values; no pending pulse.
// CONFIGURATION
//   JOHNSON_DIR_DETECT_EN defined:
//     Predecessor (prev-1 mod 2N) also counts as a good step.
//     Extra output port dir_out (1b: 1=up, 0=down; reset 0).
//     Direction latches on the first good step in ACQUIRE.
//     A step against the latched direction restarts ACQUIRE.
//     In LOCKED, a step against the latched direction -> seq_err.
//   Not defined: only successors are good steps; dir_out port absent.
// STRUCTURE
//   johnson_defs.vh: FSM state localparams (UNLOCKED=2'd0, ACQUIRE=2'd1,
//     LOCKED=2'd2), IW derivation macro; shared with counter-side blocks.
//   Sub-module johnson_code_check: combinational legality + index decode
//     (code -> legal, idx); instantiated once; reusable in other monitors.
//   Top: input decode, FSM, prev/good registers, error counter.
// TESTING (N=4, LOCK_CNT=3, EW=8)
//   Reset, feed 0000,0001,0011,0111 valid -> idx 0..3; locked=1 after 4th
//     sample, two cycles after it is applied.
//   Locked, feed 1000 then 0000 -> idx 7 then 0; no seq_err (wrap legal).
//   Locked at idx 3, feed 1100 (idx 6) -> seq_err pulse, locked=0, err_count=1.
//   Feed 0101 -> code_err pulse, idx_out unchanged, locked=0, err_count+1.
//   256 illegal samples -> err_count=255; clr_err with an error -> 1.
//   DIR_EN: 0111,0011,0001,0000 -> dir_out=0, locked=1. Then 0001 -> seq_err.

Source files
------------

// File: rtl/johnson_decoder_pkg.sv
// rtl/johnson_decoder_pkg.sv - lock-FSM states and ring-step classification shared by Johnson-code monitors
// Consumers may be built with JOHNSON_DIR_DETECT_EN to accept down-counting links.
package johnson_decoder_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  typedef enum logic [1:0] {
    STEP_HOLD  = 2'd0,
    STEP_UP    = 2'd1,
    STEP_DOWN  = 2'd2,
    STEP_OTHER = 2'd3
  } step_e;

  // Indices live on a ring of length seq_len, so the top index stepping to 0 is an ordinary up step.
  function automatic step_e classify_step(input int prev_idx, input int cur_idx, input int seq_len);
    if (cur_idx == prev_idx) return STEP_HOLD;
    if (cur_idx == (prev_idx + 1) % seq_len) return STEP_UP;
    if (cur_idx == (prev_idx + seq_len - 1) % seq_len) return STEP_DOWN;
    return STEP_OTHER;
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// rtl/johnson_code_check.sv - combinational Johnson-code legality check and index decode
// A code is legal when adjacent bits differ at no more than one position.
module johnson_code_check #(
  parameter int N  = 4,
  parameter int IW = $clog2(2 * N)
) (
  input  logic [N-1:0]  code_i,
  output logic          legal_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] edges;
  logic [IW-1:0] ones;

  always_comb begin
    edges = '0;
    ones  = '0;
    for (int i = 0; i < N - 1; i++) begin
      edges = edges + IW'(code_i[i] ^ code_i[i+1]);
    end
    for (int i = 0; i < N; i++) begin
      ones = ones + IW'(code_i[i]);
    end
    legal_o = (edges <= IW'(1));
    // With the MSB set the index is N + zeros = 2N - ones; modular arithmetic keeps this exact.
    idx_o = code_i[N-1] ? (IW'(2 * N) - ones) : ones;
  end

endmodule

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson-link receiver: decode, step-order lock FSM, saturating error counter
// Build macro JOHNSON_DIR_DETECT_EN adds predecessor steps as good steps and the dir_out port.
module johnson_decoder
  import johnson_decoder_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int LOCK_CNT = 3,
  parameter  int EW       = 8,
  localparam int IW       = $clog2(2 * N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  code_in,
  input  logic          code_valid,
  input  logic          clr_err,
  output logic [IW-1:0] idx_out,
  output logic          idx_valid,
  output logic          code_err,
  output logic          seq_err,
  output logic          locked,
  output logic [EW-1:0] err_count
`ifdef JOHNSON_DIR_DETECT_EN
  ,
  output logic          dir_out
`endif
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  logic          legal;
  logic [IW-1:0] idx;

  johnson_code_check #(
    .N  (N),
    .IW (IW)
  ) u_code_check (
    .code_i  (code_in),
    .legal_o (legal),
    .idx_o   (idx)
  );

  lock_state_e   state_q;
  logic [IW-1:0] prev_q;
  logic [IW-1:0] idx_q;
  logic [GW-1:0] good_q;
  logic          idx_valid_q;
  logic          code_err_q;
  logic          seq_err_q;
  logic          locked_q;
  logic [EW-1:0] err_q;
`ifdef JOHNSON_DIR_DETECT_EN
  logic          dir_q;
`endif

  step_e         step;
  step_e         fwd_step;
  logic          acq_good;
  logic [GW-1:0] good_d;
  logic          code_err_d;
  logic          seq_err_d;
  logic          err_event;

  always_comb begin
    step = classify_step(int'(prev_q), int'(idx), 2 * N);
`ifdef JOHNSON_DIR_DETECT_EN
    fwd_step = dir_q ? STEP_UP : STEP_DOWN;
    // Until a direction is latched either neighbour counts as the first good step.
    acq_good = (good_q == '0) ? (step == STEP_UP || step == STEP_DOWN) : (step == fwd_step);
`else
    fwd_step = STEP_UP;
    acq_good = (step == STEP_UP);
`endif
    good_d     = good_q + 1'b1;
    code_err_d = code_valid && !legal;
    seq_err_d  = code_valid && legal && (state_q == LOCKED) &&
                 (step != STEP_HOLD) && (step != fwd_step);
    err_event  = code_err_d || seq_err_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      prev_q      <= '0;
      idx_q       <= '0;
      good_q      <= '0;
      idx_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= '0;
`ifdef JOHNSON_DIR_DETECT_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      idx_valid_q <= code_valid && legal;
      code_err_q  <= code_err_d;
      seq_err_q   <= seq_err_d;
      // locked trails the FSM by one register stage.
      locked_q    <= (state_q == LOCKED);

      if (clr_err) begin
        err_q <= err_event ? EW'(1) : '0;
      end else if (err_event && (err_q != '1)) begin
        err_q <= err_q + 1'b1;
      end

      if (code_valid) begin
        if (!legal) begin
          state_q <= UNLOCKED;
          good_q  <= '0;
        end else begin
          idx_q  <= idx;
          prev_q <= idx;
          case (state_q)
            UNLOCKED: begin
              good_q  <= '0;
              state_q <= ACQUIRE;
            end
            ACQUIRE: begin
              if (step != STEP_HOLD) begin
                if (acq_good) begin
`ifdef JOHNSON_DIR_DETECT_EN
                  dir_q <= (step == STEP_UP);
`endif
                  if (good_d == GW'(LOCK_CNT)) begin
                    state_q <= LOCKED;
                    good_q  <= '0;
                  end else begin
                    good_q <= good_d;
                  end
                end else begin
                  good_q <= '0;
                end
              end
            end
            LOCKED: begin
              if (seq_err_d) begin
                state_q <= UNLOCKED;
                good_q  <= '0;
              end
            end
            default: begin
              state_q <= UNLOCKED;
              good_q  <= '0;
            end
          endcase
        end
      end
    end
  end

  assign idx_out   = idx_q;
  assign idx_valid = idx_valid_q;
  assign code_err  = code_err_q;
  assign seq_err   = seq_err_q;
  assign locked    = locked_q;
  assign err_count = err_q;
`ifdef JOHNSON_DIR_DETECT_EN
  assign dir_out   = dir_q;
`endif

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - scoreboard bench for johnson_decoder against a table-driven reference model
module tb_johnson_decoder;

  localparam int N        = 4;
  localparam int LOCK_CNT = 3;
  localparam int EW       = 8;
  localparam int IW       = $clog2(2 * N);
  localparam int LEN      = 2 * N;
  localparam int EMAX     = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  code_in = '0;
  logic          code_valid = 1'b0;
  logic          clr_err = 1'b0;
  logic [IW-1:0] idx_out;
  logic          idx_valid;
  logic          code_err;
  logic          seq_err;
  logic          locked;
  logic [EW-1:0] err_count;
`ifdef JOHNSON_DIR_DETECT_EN
  logic          dir_out;
`endif

  johnson_decoder #(
    .N        (N),
    .LOCK_CNT (LOCK_CNT),
    .EW       (EW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .clr_err    (clr_err),
    .idx_out    (idx_out),
    .idx_valid  (idx_valid),
    .code_err   (code_err),
    .seq_err    (seq_err),
    .locked     (locked),
    .err_count  (err_count)
`ifdef JOHNSON_DIR_DETECT_EN
    ,
    .dir_out    (dir_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
    logic          cerr;
    logic          serr;
    logic [EW-1:0] ecnt;
    logic          lk;
    logic          dir;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model state: 0 = unlocked, 1 = acquiring, 2 = locked.
  int   m_state = 0;
  int   m_prev = 0;
  int   m_idx = 0;
  int   m_good = 0;
  int   m_err = 0;
  bit   m_dir = 1'b0;
  bit   mon_lk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [N-1:0] jcode(input int k);
    int v;
    if (k < N) v = (1 << k) - 1;
    else v = ((1 << N) - 1) ^ ((1 << (k - N)) - 1);
    return v[N-1:0];
  endfunction

  function automatic int decode(input logic [N-1:0] c);
    for (int k = 0; k < LEN; k++) begin
      if (jcode(k) == c) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] rand_illegal();
    logic [31:0] r;
    r = $urandom;
    while (decode(r[N-1:0]) >= 0) r = $urandom;
    return r[N-1:0];
  endfunction

  task automatic model_sample(input logic [N-1:0] c, input logic clr);
    exp_t e;
    int   k;
    bit   up;
    bit   dn;
    bit   good;
    bit   ev;
    k = decode(c);
    e = '0;
    e.vld  = (k >= 0);
    e.cerr = (k < 0);
    if (k < 0) begin
      m_state = 0;
      m_good  = 0;
    end else begin
      up = (k == (m_prev + 1) % LEN);
      dn = (k == (m_prev + LEN - 1) % LEN);
      if (m_state == 0) begin
        m_state = 1;
        m_good  = 0;
      end else if (k != m_prev) begin
`ifdef JOHNSON_DIR_DETECT_EN
        good = (m_state == 1 && m_good == 0) ? (up || dn) : (m_dir ? up : dn);
`else
        good = up;
`endif
        if (m_state == 1) begin
          if (good) begin
`ifdef JOHNSON_DIR_DETECT_EN
            m_dir = up;
`endif
            m_good++;
            if (m_good == LOCK_CNT) begin
              m_state = 2;
              m_good  = 0;
            end
          end else begin
            m_good = 0;
          end
        end else if (!good) begin
          e.serr  = 1'b1;
          m_state = 0;
          m_good  = 0;
        end
      end
      m_prev = k;
      m_idx  = k;
    end
    ev = e.cerr || e.serr;
    if (clr) m_err = ev ? 1 : 0;
    else if (ev && m_err < EMAX) m_err++;
    e.idx  = m_idx[IW-1:0];
    e.ecnt = m_err[EW-1:0];
    e.lk   = (m_state == 2);
    e.dir  = m_dir;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [N-1:0] c, input logic v, input logic clr);
    @(negedge clk);
    code_in    = c;
    code_valid = v;
    clr_err    = clr;
    if (v) model_sample(c, clr);
    else if (clr) m_err = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send('0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    code_valid = 1'b0;
    clr_err    = 1'b0;
    code_in    = '0;
    exp_q.delete();
    m_state = 0;
    m_prev  = 0;
    m_idx   = 0;
    m_good  = 0;
    m_err   = 0;
    m_dir   = 1'b0;
    #1;
    check("rst_idx_out", idx_out, 0);
    check("rst_idx_valid", idx_valid, 0);
    check("rst_code_err", code_err, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_locked", locked, 0);
    check("rst_err_count", err_count, 0);
`ifdef JOHNSON_DIR_DETECT_EN
    check("rst_dir_out", dir_out, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: locked reflects the FSM state after the previous event; every pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mon_lk = 1'b0;
    end else begin
      check("locked", locked, mon_lk);
      if (idx_valid || code_err || seq_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: idx_valid=%0d code_err=%0d seq_err=%0d with no pending sample",
                   idx_valid, code_err, seq_err);
        end else begin
          e = exp_q.pop_front();
          check("idx_valid", idx_valid, e.vld);
          check("idx_out", idx_out, e.idx);
          check("code_err", code_err, e.cerr);
          check("seq_err", seq_err, e.serr);
          check("err_count", err_count, e.ecnt);
`ifdef JOHNSON_DIR_DETECT_EN
          check("dir_out", dir_out, e.dir);
`endif
          mon_lk = e.lk;
        end
      end
    end
  end

  initial begin
    logic [31:0] r;
    logic [N-1:0] c;
    int sel;
    #2;
    apply_reset();

    send(4'b0000, 1'b1, 1'b0);
    send(4'b0001, 1'b1, 1'b0);
    send(4'b0011, 1'b1, 1'b0);
    send(4'b0111, 1'b1, 1'b0);
    idle(2);
    check("locked_after_acquire", locked, 1);

    send(4'b1111, 1'b1, 1'b0);
    send(4'b1110, 1'b1, 1'b0);
    send(4'b1100, 1'b1, 1'b0);
    send(4'b1000, 1'b1, 1'b0);
    send(4'b0000, 1'b1, 1'b0);
    idle(2);
    check("locked_after_wrap", locked, 1);
    check("err_after_wrap", err_count, 0);

    send(4'b0001, 1'b1, 1'b0);
    send(4'b0011, 1'b1, 1'b0);
    send(4'b0111, 1'b1, 1'b0);
    send(4'b1100, 1'b1, 1'b0);
    idle(2);
    check("locked_after_seq_err", locked, 0);
    check("err_after_seq_err", err_count, 1);

    send(4'b0101, 1'b1, 1'b0);
    idle(2);
    check("idx_held_on_code_err", idx_out, 6);
    check("err_after_code_err", err_count, 2);

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 99);
      r = $urandom;
      if (sel < 45) c = jcode((m_prev + 1) % LEN);
`ifdef JOHNSON_DIR_DETECT_EN
      else if (sel < 55) c = jcode((m_prev + LEN - 1) % LEN);
`endif
      else if (sel < 63) c = jcode(m_prev);
      else if (sel < 82) c = jcode($urandom_range(0, LEN - 1));
      else c = r[N-1:0];
      send(c, ($urandom_range(0, 7) != 0), ($urandom_range(0, 40) == 0));
    end
    idle(2);

    send('0, 1'b0, 1'b1);
    idle(1);
    check("clr_alone", err_count, 0);
    for (int i = 0; i < 256; i++) send(rand_illegal(), 1'b1, 1'b0);
    idle(2);
    check("err_saturated", err_count, EMAX);
    send(rand_illegal(), 1'b1, 1'b1);
    idle(2);
    check("clr_with_error", err_count, 1);

    send(jcode((m_prev + 1) % LEN), 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("pulse_before_reset", idx_valid, 1);
    apply_reset();
    idle(2);
    check("no_pulse_after_reset", idx_valid, 0);

`ifdef JOHNSON_DIR_DETECT_EN
    send(4'b0111, 1'b1, 1'b0);
    send(4'b0011, 1'b1, 1'b0);
    send(4'b0001, 1'b1, 1'b0);
    send(4'b0000, 1'b1, 1'b0);
    idle(2);
    check("dir_down_latched", dir_out, 0);
    check("dir_locked", locked, 1);
    send(4'b0001, 1'b1, 1'b0);
    idle(2);
    check("dir_against_unlocks", locked, 0);
    check("dir_err_count", err_count, 1);
`endif

    idle(3);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
